// File: rtl/pipe_perf_pkg.sv
// Shared types and helpers for the pipeline performance monitor.
// The state encoding, the cycle-channel index and the counter all-ones value live here.
package pipe_perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_CNT_W = 64;

  // The cycle counter sits directly after the event channels.
  function automatic int cycle_chan(input int num_evt);
    return num_evt;
  endfunction

  function automatic logic [MAX_CNT_W-1:0] all_ones(input int width);
    logic [MAX_CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_CNT_W; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// One live event/cycle counter with a sticky overflow flag.
// At all-ones an increment either holds the value or wraps to zero, depending on SATURATE.
module perf_counter
  import pipe_perf_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [MAX_CNT_W-1:0] ONES_WIDE = all_ones(CNT_W);
  localparam logic [CNT_W-1:0]     CNT_MAX   = ONES_WIDE[CNT_W-1:0];

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (inc) begin
      if (r_cnt == CNT_MAX) begin
        r_ovf <= 1'b1;
        r_cnt <= SATURATE ? CNT_MAX : '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign cnt = r_cnt;
  assign ovf = r_ovf;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Performance monitor: cycle and per-event counters under an IDLE/RUN/DONE
// state machine, read back through a snapshot shadow bank with a registered mux.
module pipe_perf_monitor
  import pipe_perf_pkg::*;
#(
  parameter int NUM_EVT     = 2,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 64,
  parameter bit SATURATE    = 1'b1,
  parameter int SEL_W       = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               clear_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               running_o,
  output logic               done_o,
  output logic [NUM_EVT:0]   ovf_o
);

  localparam int               CYC_IDX  = cycle_chan(NUM_EVT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = (CYCLE_LIMIT == 0) ? '0 : CNT_W'(CYCLE_LIMIT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_run;
  logic             w_cyc_last;
  logic [NUM_EVT:0] w_inc;
  logic [NUM_EVT:0] w_ovf;
  logic [CNT_W-1:0] w_cnt    [NUM_EVT+1];
  logic [CNT_W-1:0] r_shadow [NUM_EVT+1];
  logic [CNT_W-1:0] w_rd_mux;
  logic [CNT_W-1:0] r_rd_data;

  assign w_run = (r_state == RUN);
  // Gating with w_run keeps an X on evt_i out of the counters outside RUN.
  assign w_inc = {1'b1, evt_i} & {(NUM_EVT + 1){w_run}};

  for (genvar k = 0; k <= NUM_EVT; k++) begin : g_cnt
    perf_counter #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) u_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .clr  (clear_i),
      .inc  (w_inc[k]),
      .cnt  (w_cnt[k]),
      .ovf  (w_ovf[k])
    );
  end

  // The cycle counter reaches CYCLE_LIMIT on this edge.
  assign w_cyc_last = (CYCLE_LIMIT != 0) && w_run && (w_cnt[CYC_IDX] == LIMIT_M1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start_i)    w_state_nxt = RUN;
      RUN:     if (w_cyc_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
    if (clear_i) w_state_nxt = IDLE;
  end

  // NOTE: the shadow bank is a handful of flops, not a RAM, and must read
  // back zero after reset, so it is reset like any other register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k <= NUM_EVT; k++) r_shadow[k] <= '0;
    end else if (clear_i) begin
      for (int k = 0; k <= NUM_EVT; k++) r_shadow[k] <= '0;
    end else if (snap_i) begin
      for (int k = 0; k <= NUM_EVT; k++) r_shadow[k] <= w_cnt[k];
    end
  end

  always_comb begin
    w_rd_mux = '0;
    for (int k = 0; k <= NUM_EVT; k++) begin
      if (rd_sel_i == SEL_W'(k)) w_rd_mux = r_shadow[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_rd_data <= '0;
    else       r_rd_data <= w_rd_mux;
  end

  assign rd_data_o = r_rd_data;
  assign running_o = (r_state == RUN);
  assign done_o    = (r_state == DONE);
  assign ovf_o     = w_ovf;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: a default instance plus 8-bit saturating
// and wrapping instances, all sharing one stimulus sequence.
module tb_pipe_perf_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  evt;
  logic        clear;
  logic        snap;
  logic [4:0]  rd_sel;

  logic [31:0] rd_a;
  logic        run_a, done_a;
  logic [2:0]  ovf_a;
  logic [7:0]  rd_s, rd_w;
  logic        run_s, done_s, run_w, done_w;
  logic [2:0]  ovf_s, ovf_w;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(32), .CYCLE_LIMIT(64), .SATURATE(1'b1), .SEL_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clear_i(clear), .snap_i(snap),
    .rd_sel_i(rd_sel), .rd_data_o(rd_a), .running_o(run_a), .done_o(done_a), .ovf_o(ovf_a));

  pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(8), .CYCLE_LIMIT(0), .SATURATE(1'b1), .SEL_W(5)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clear_i(clear), .snap_i(snap),
    .rd_sel_i(rd_sel), .rd_data_o(rd_s), .running_o(run_s), .done_o(done_s), .ovf_o(ovf_s));

  pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(8), .CYCLE_LIMIT(0), .SATURATE(1'b0), .SEL_W(5)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clear_i(clear), .snap_i(snap),
    .rd_sel_i(rd_sel), .rd_data_o(rd_w), .running_o(run_w), .done_o(done_w), .ovf_o(ovf_w));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; evt = 2'b00; clear = 1'b0; snap = 1'b0; rd_sel = '0;
    #12 rst = 1'b0;
    @(negedge clk);
    check("rst_run", 64'(run_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_rd", 64'(rd_a), 64'd0);
    check("rst_ovf", 64'(ovf_a), 64'd0);

    // Async reset in the middle of a run.
    start = 1'b1; step(); start = 1'b0;
    evt = 2'b11;
    repeat (10) step();
    evt = 2'b00; snap = 1'b1; step(); snap = 1'b0;
    rd_sel = 5'd0; step();
    check("mid_rd_pre", 64'(rd_a), 64'd10);
    check("mid_run_pre", 64'(run_a), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rd", 64'(rd_a), 64'd0);
    check("async_run", 64'(run_a), 64'd0);
    check("async_done", 64'(done_a), 64'd0);
    check("async_ovf", 64'(ovf_a), 64'd0);
    check("async_rd_sat", 64'(rd_s), 64'd0);
    #1 rst = 1'b0;
    step();
    check("post_rst_rd", 64'(rd_a), 64'd0);
    check("post_rst_run", 64'(run_a), 64'd0);

    // Basic run to the 64-cycle limit.
    start = 1'b1; step(); start = 1'b0;
    check("basic_running", 64'(run_a), 64'd1);
    for (int i = 0; i < 64; i++) begin
      evt = {(i < 5) ? 1'b1 : 1'b0, (i % 3 == 0) ? 1'b1 : 1'b0};
      step();
      if (i == 62) begin
        check("done_before_limit", 64'(done_a), 64'd0);
        check("run_before_limit", 64'(run_a), 64'd1);
      end
      if (i == 63) begin
        check("done_at_limit", 64'(done_a), 64'd1);
        check("run_at_limit", 64'(run_a), 64'd0);
      end
    end
    evt = 2'b11;
    repeat (3) step();
    evt = 2'b00;
    snap = 1'b1; step(); snap = 1'b0;
    rd_sel = 5'd0; step();
    check("basic_sel0", 64'(rd_a), 64'd22);
    rd_sel = 5'd2;
    check("rd_latency_hold", 64'(rd_a), 64'd22);
    step();
    check("basic_sel2", 64'(rd_a), 64'd64);
    rd_sel = 5'd1; step();
    check("basic_sel1", 64'(rd_a), 64'd5);
    rd_sel = 5'd3; step();
    check("rd_oob3", 64'(rd_a), 64'd0);
    rd_sel = 5'd31; step();
    check("rd_oob31", 64'(rd_a), 64'd0);
    check("basic_ovf", 64'(ovf_a), 64'd0);

    // DONE ignores start; clear returns to IDLE and counting restarts from 0.
    start = 1'b1; step(); start = 1'b0; step();
    check("done_sticky", 64'(done_a), 64'd1);
    check("done_no_run", 64'(run_a), 64'd0);
    snap = 1'b1; step(); snap = 1'b0;
    rd_sel = 5'd2; step();
    check("done_cyc_frozen", 64'(rd_a), 64'd64);
    clear = 1'b1; step(); clear = 1'b0;
    check("clr_done", 64'(done_a), 64'd0);
    check("clr_run", 64'(run_a), 64'd0);
    start = 1'b1; step(); start = 1'b0;
    check("restart_run", 64'(run_a), 64'd1);
    evt = 2'b10;
    repeat (3) step();
    evt = 2'b00; snap = 1'b1; step(); snap = 1'b0;
    rd_sel = 5'd2; step();
    check("restart_cyc", 64'(rd_a), 64'd3);
    rd_sel = 5'd1; step();
    check("restart_ch1", 64'(rd_a), 64'd3);
    rd_sel = 5'd0; step();
    check("restart_ch0", 64'(rd_a), 64'd0);

    // Snapshot coincident with an increment captures the pre-increment value.
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    evt = 2'b01;
    repeat (7) step();
    snap = 1'b1; step(); snap = 1'b0; evt = 2'b00;
    rd_sel = 5'd0; step();
    check("simul_shadow", 64'(rd_a), 64'd7);
    snap = 1'b1; step(); snap = 1'b0;
    step();
    check("simul_live", 64'(rd_a), 64'd8);
    clear = 1'b1; start = 1'b1; snap = 1'b1; evt = 2'b11;
    step();
    clear = 1'b0; start = 1'b0; snap = 1'b0; evt = 2'b00;
    check("clr_wins_run", 64'(run_a), 64'd0);
    check("clr_wins_done", 64'(done_a), 64'd0);
    check("clr_wins_ovf", 64'(ovf_a), 64'd0);
    step();
    check("clr_wins_shadow0", 64'(rd_a), 64'd0);
    rd_sel = 5'd2; step();
    check("clr_wins_shadow2", 64'(rd_a), 64'd0);
    snap = 1'b1; step(); snap = 1'b0; step();
    check("clr_wins_live2", 64'(rd_a), 64'd0);
    check("clr_wins_idle", 64'(run_a), 64'd0);

    // 300 cycles into 8-bit counters: saturate vs wrap.
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    evt = 2'b01;
    repeat (300) step();
    evt = 2'b00;
    check("sat_ovf", 64'(ovf_s), 64'd5);
    check("wrap_ovf", 64'(ovf_w), 64'd5);
    check("sat_still_run", 64'(run_s), 64'd1);
    check("limit_done", 64'(done_a), 64'd1);
    snap = 1'b1; step(); snap = 1'b0;
    rd_sel = 5'd0; step();
    check("sat_sel0", 64'(rd_s), 64'd255);
    check("wrap_sel0", 64'(rd_w), 64'd44);
    rd_sel = 5'd2; step();
    check("sat_sel2", 64'(rd_s), 64'd255);
    check("wrap_sel2", 64'(rd_w), 64'd44);
    rd_sel = 5'd1; step();
    check("sat_sel1", 64'(rd_s), 64'd0);
    check("wrap_sel1", 64'(rd_w), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
